vliw_dmem_arbiter: RTL and testbench
====================================

# vliw_dmem_arbiter

Arbitrates the single-port data memory between the two issue slots of the VLIW bundle: the 32-bit slot (SW stores) and the compressed slot (C.LW loads). Captures the memory operations of an accepted bundle, serialises them in program order (32-bit slot first), drives a ready/request handshake to data memory, and stalls the pipeline until both operations complete. Sits in the MEM stage, between the control-decoded bundle (memWrite / memReadc) and data memory. Also keeps two saturating performance counters.

## Interface
- AW, 32, address width (byte address)
- DW, 32, data width
- CNTW, 16, performance counter width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- bundle_valid  in  1  MEM-stage bundle present
- a_we  in  1  32-bit slot store (memWrite)
- a_addr  in  AW  store byte address
- a_wdata  in  DW  store data
- c_re  in  1  compressed slot load (memReadc)
- c_addr  in  AW  load byte address
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  AW  word-aligned address ([1:0] forced 0)
- mem_wdata  out  DW  write data
- mem_rdata  in  DW  read data, valid when mem_ready & ~mem_we
- mem_ready  in  1  memory completes current request this cycle
- c_rdata  out  DW  load result for compressed slot
- c_rvalid  out  1  one-cycle pulse, c_rdata valid
- stall  out  1  freeze IF/ID/EX/MEM pipeline registers
- conflict_cnt  out  CNTW  bundles containing both a store and a load
- stall_cnt  out  CNTW  cycles with stall = 1

## Operation
- States: IDLE, REQ_A, REQ_C.
- Accept: in IDLE, rising edge with bundle_valid = 1 latches a_we, a_addr, a_wdata, c_re, c_addr. bundle_valid while not IDLE is ignored (pipeline is stalled and holds the bundle).
- IDLE -> REQ_A if a_we; -> REQ_C if ~a_we & c_re; stays IDLE if neither (no stall).
- REQ_A: mem_req = 1, mem_we = 1, mem_addr/mem_wdata from latched store. On mem_ready: -> REQ_C if latched c_re, else -> IDLE.
- REQ_C: mem_req = 1, mem_we = 0, mem_addr from latched load. On mem_ready: c_rdata <= mem_rdata, -> IDLE.
- Program order fixed: store before load, so same-address C.LW returns the newly stored word.
- mem_req, mem_we, mem_addr, mem_wdata stable from request assertion until the mem_ready cycle inclusive; mem_req deasserted the cycle after the final mem_ready. In IDLE: mem_req = 0, mem_we = 0, mem_addr/mem_wdata = 0.
- stall = (state != IDLE), registered.
- conflict_cnt increments on accept with a_we & c_re; stall_cnt increments each cycle stall = 1; both saturate at all-ones, never wrap.
- Address bits [1:0] dropped on mem_addr; no misalignment trap.

## Timing
- Reset (async, immediate): state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, c_rdata 0, c_rvalid 0, stall 0, both counters 0. Reset mid-transaction abandons it; no request survives reset.
- Accept edge T: stall and mem_req rise at T (visible cycle after accept).
- Zero-wait memory (mem_ready same cycle as mem_req): single op = 1 stall cycle; store+load = 2 stall cycles.
- Wait states: each op occupies (wait+1) cycles; REQ_A -> REQ_C transition has no idle gap.
- c_rvalid pulses the cycle after the load's mem_ready, coincident with stall = 0; c_rdata holds until next load completes.
- Next bundle accepted on the first edge where state is IDLE (earliest cycle stall reads 0).
- mem_ready while mem_req = 0 ignored.

## Test plan
- Reset: drive rst_n low mid REQ_A with mem_req = 1 -> mem_req, stall, counters go 0 immediately without clock; IDLE after release.
- Store only, zero-wait: a_we = 1, a_addr = 0x103, a_wdata = 0xDEADBEEF, mem_ready tied 1 -> one cycle mem_req = 1, mem_we = 1, mem_addr = 0x100; stall high 1 cycle; stall_cnt = 1.
- Load only, 2 wait states: c_re = 1, c_addr = 0x40, mem_rdata = 0x12345678 on 3rd request cycle -> mem_req held 3 cycles, c_rvalid pulse next cycle with c_rdata = 0x12345678; stall_cnt = 3.
- Conflict bundle same address 0x200, store 0xA5A5A5A5, memory model -> write cycle then read cycle, c_rdata = 0xA5A5A5A5; conflict_cnt = 1; no idle cycle between requests.
- No-op bundles back-to-back (a_we = c_re = 0) for 10 cycles -> stall never asserts, mem_req stays 0, counters unchanged.
- Saturation: preload via 65,540 conflict bundles (CNTW = 16) -> conflict_cnt holds 0xFFFF, does not wrap.

Source files
------------

// File: rtl/vliw_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// vliw_dmem_arbiter
//
// Shares the single-port data memory between the two VLIW issue slots.
// The 32-bit slot may issue a store (SW). The compressed slot may issue a
// load (C.LW). An accepted bundle's operations run one at a time, store
// first, over a req/ready handshake. The pipeline is stalled until both
// operations have completed.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   bundle_valid          MEM-stage bundle present (sampled only in IDLE)
//   a_we/a_addr/a_wdata   32-bit slot store
//   c_re/c_addr           compressed slot load
//   mem_req/mem_we        memory request, 1 = write / 0 = read
//   mem_addr/mem_wdata    word-aligned address, store data
//   mem_rdata/mem_ready   read data, completion of the current request
//   c_rdata/c_rvalid      load result and its one-cycle valid pulse
//   stall                 freeze IF/ID/EX/MEM while an operation is pending
//   conflict_cnt          saturating count of bundles with store and load
//   stall_cnt             saturating count of stalled cycles
// ---------------------------------------------------------------------------
module vliw_dmem_arbiter #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            bundle_valid,
  input  logic            a_we,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_wdata,
  input  logic            c_re,
  input  logic [AW-1:0]   c_addr,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic [DW-1:0]   c_rdata,
  output logic            c_rvalid,
  output logic            stall,
  output logic [CNTW-1:0] conflict_cnt,
  output logic [CNTW-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ_A = 2'd1,
    REQ_C = 2'd2
  } state_t;

  // Clears the byte offset; memory is word addressed.
  localparam logic [AW-1:0] ADDR_MASK = {{(AW-2){1'b1}}, 2'b00};
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  state_t          state_r;
  logic            c_pend_r;   // load still to be issued after the store
  logic [AW-1:0]   c_addr_r;   // latched load address

  // Saturating increment; performance counters must never wrap.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      c_pend_r     <= 1'b0;
      c_addr_r     <= {AW{1'b0}};
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= {AW{1'b0}};
      mem_wdata    <= {DW{1'b0}};
      c_rdata      <= {DW{1'b0}};
      c_rvalid     <= 1'b0;
      stall        <= 1'b0;
      conflict_cnt <= {CNTW{1'b0}};
      stall_cnt    <= {CNTW{1'b0}};
    end else begin
      c_rvalid <= 1'b0;
      if (stall) begin
        stall_cnt <= sat_inc(stall_cnt);
      end else begin
        stall_cnt <= stall_cnt;
      end

      case (state_r)
        IDLE: begin
          if (bundle_valid && a_we) begin
            state_r   <= REQ_A;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= a_addr & ADDR_MASK;
            mem_wdata <= a_wdata;
            stall     <= 1'b1;
            c_pend_r  <= c_re;
            c_addr_r  <= c_addr;
            if (c_re) begin
              conflict_cnt <= sat_inc(conflict_cnt);
            end else begin
              conflict_cnt <= conflict_cnt;
            end
          end else if (bundle_valid && c_re) begin
            state_r   <= REQ_C;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= c_addr & ADDR_MASK;
            mem_wdata <= {DW{1'b0}};
            stall     <= 1'b1;
            c_pend_r  <= 1'b0;
            c_addr_r  <= c_addr;
          end else begin
            // Nothing to do: no request, no stall.
            state_r <= IDLE;
          end
        end

        REQ_A: begin
          if (mem_ready && c_pend_r) begin
            // Go straight to the load, no idle gap between requests.
            state_r   <= REQ_C;
            mem_we    <= 1'b0;
            mem_addr  <= c_addr_r & ADDR_MASK;
            mem_wdata <= {DW{1'b0}};
            c_pend_r  <= 1'b0;
          end else if (mem_ready) begin
            state_r   <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {AW{1'b0}};
            mem_wdata <= {DW{1'b0}};
            stall     <= 1'b0;
          end else begin
            state_r <= REQ_A;
          end
        end

        REQ_C: begin
          if (mem_ready) begin
            state_r   <= IDLE;
            c_rdata   <= mem_rdata;
            c_rvalid  <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {AW{1'b0}};
            mem_wdata <= {DW{1'b0}};
            stall     <= 1'b0;
          end else begin
            state_r <= REQ_C;
          end
        end

        default: begin
          state_r   <= IDLE;
          c_pend_r  <= 1'b0;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= {AW{1'b0}};
          mem_wdata <= {DW{1'b0}};
          stall     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vliw_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vliw_dmem_arbiter
//
// Drives bundles and plays the data memory. Every bundle is described as a
// list of memory operations: the store first, then the load. Each operation
// lasts (wait + 1) cycles. A word-addressed memory model gives the expected
// load data. The counters are modelled as plain saturating integers.
// CNTW is set to 8 so that saturation is reached in a short run.
// ---------------------------------------------------------------------------
module tb_vliw_dmem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int CNTW = 8;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            bundle_valid;
  logic            a_we;
  logic [AW-1:0]   a_addr;
  logic [DW-1:0]   a_wdata;
  logic            c_re;
  logic [AW-1:0]   c_addr;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ready;
  logic [DW-1:0]   c_rdata;
  logic            c_rvalid;
  logic            stall;
  logic [CNTW-1:0] conflict_cnt;
  logic [CNTW-1:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  logic [31:0] mem_model [logic [31:0]];
  int          model_conf;
  int          model_stall;
  logic [31:0] last_rdata;

  vliw_dmem_arbiter #(.AW(AW), .DW(DW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .bundle_valid(bundle_valid),
    .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .c_re(c_re), .c_addr(c_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .c_rdata(c_rdata), .c_rvalid(c_rvalid), .stall(stall),
    .conflict_cnt(conflict_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] wa);
    if (mem_model.exists(wa)) return mem_model[wa];
    else return wa ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check_counters(input string tag);
    chk({tag, "_conflict_cnt"}, 64'(conflict_cnt), 64'(model_conf));
    chk({tag, "_stall_cnt"},    64'(stall_cnt),    64'(model_stall));
  endtask

  // One bundle: accept, then each memory operation for (wait + 1) cycles.
  task automatic run_bundle(input bit we, input logic [31:0] aaddr,
                            input logic [31:0] wdata, input bit re,
                            input logic [31:0] caddr, input int wa, input int wc);
    logic [31:0] exp_rd;
    exp_rd       = 32'h0;
    bundle_valid = 1'b1;
    a_we = we; a_addr = aaddr; a_wdata = wdata;
    c_re = re; c_addr = caddr;
    mem_ready = 1'b0;
    step();
    // The bundle is latched; scramble the inputs to prove it.
    bundle_valid = 1'b0;
    a_we = 1'($urandom); a_addr = $urandom; a_wdata = $urandom;
    c_re = 1'($urandom); c_addr = $urandom;
    if (we && re) model_conf = sat(model_conf);
    if (we) begin
      for (int k = 0; k <= wa; k++) begin
        chk("st_req",   64'(mem_req),   64'(1'b1));
        chk("st_we",    64'(mem_we),    64'(1'b1));
        chk("st_addr",  64'(mem_addr),  64'(word_of(aaddr)));
        chk("st_wdata", 64'(mem_wdata), 64'(wdata));
        chk("st_stall", 64'(stall),     64'(1'b1));
        mem_ready = (k == wa);
        mem_rdata = $urandom;
        step();
        model_stall = sat(model_stall);
      end
      mem_model[word_of(aaddr)] = wdata;
    end
    if (re) begin
      exp_rd = mem_read(word_of(caddr));
      for (int k = 0; k <= wc; k++) begin
        chk("ld_req",   64'(mem_req),  64'(1'b1));
        chk("ld_we",    64'(mem_we),   64'(1'b0));
        chk("ld_addr",  64'(mem_addr), 64'(word_of(caddr)));
        chk("ld_stall", 64'(stall),    64'(1'b1));
        chk("ld_rvalid_early", 64'(c_rvalid), 64'(1'b0));
        mem_ready = (k == wc);
        mem_rdata = (k == wc) ? exp_rd : $urandom;
        step();
        model_stall = sat(model_stall);
      end
      last_rdata = exp_rd;
    end
    mem_ready = 1'b0;
    chk("end_req",    64'(mem_req),  64'(1'b0));
    chk("end_we",     64'(mem_we),   64'(1'b0));
    chk("end_addr",   64'(mem_addr), 64'(0));
    chk("end_stall",  64'(stall),    64'(1'b0));
    chk("end_rvalid", 64'(c_rvalid), 64'(re));
    chk("end_rdata",  64'(c_rdata),  64'(last_rdata));
    check_counters("end");
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0; bundle_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    c_re = 1'b0; c_addr = '0; mem_rdata = '0; mem_ready = 1'b0;
    model_conf = 0; model_stall = 0; last_rdata = 32'h0;
    #2;
    chk("rst_req",   64'(mem_req),   64'(1'b0));
    chk("rst_stall", 64'(stall),     64'(1'b0));
    chk("rst_rdata", 64'(c_rdata),   64'(0));
    chk("rst_wdata", 64'(mem_wdata), 64'(0));
    check_counters("rst");
    step();
    rst_n = 1'b1;
    step();

    // Conflict bundle, then reset in the middle of the store request
    run_bundle(1'b1, 32'h300, 32'h1111_2222, 1'b1, 32'h304, 0, 0);
    bundle_valid = 1'b1; a_we = 1'b1; a_addr = 32'h500; a_wdata = 32'hCAFE_F00D;
    c_re = 1'b1; c_addr = 32'h504;
    step();
    bundle_valid = 1'b0;
    chk("mid_req_before", 64'(mem_req), 64'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_req",   64'(mem_req), 64'(1'b0));
    chk("mid_stall", 64'(stall),   64'(1'b0));
    chk("mid_rdata", 64'(c_rdata), 64'(0));
    model_conf = 0; model_stall = 0; last_rdata = 32'h0;
    check_counters("mid");
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_req",   64'(mem_req), 64'(1'b0));
    chk("post_rst_stall", 64'(stall),   64'(1'b0));

    // Store only, zero wait, unaligned byte address
    run_bundle(1'b1, 32'h103, 32'hDEAD_BEEF, 1'b0, 32'h0, 0, 0);
    chk("store_only_stall_cnt", 64'(stall_cnt), 64'(1));

    // Load only, two wait states
    mem_model[32'h40] = 32'h1234_5678;
    run_bundle(1'b0, 32'h0, 32'h0, 1'b1, 32'h40, 0, 2);
    chk("load_only_rdata", 64'(c_rdata), 64'(32'h1234_5678));

    // Same-address conflict: load must see the new store
    run_bundle(1'b1, 32'h200, 32'hA5A5_A5A5, 1'b1, 32'h202, 1, 1);
    chk("conflict_rdata", 64'(c_rdata), 64'(32'hA5A5_A5A5));

    // No-op bundles back to back, with stray mem_ready
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bundle_valid = 1'b1; a_we = 1'b0; c_re = 1'b0; a_addr = $urandom; c_addr = $urandom;
      step();
      chk("noop_stall",  64'(stall),    64'(1'b0));
      chk("noop_req",    64'(mem_req),  64'(1'b0));
      chk("noop_rvalid", 64'(c_rvalid), 64'(1'b0));
      check_counters("noop");
    end
    bundle_valid = 1'b0;
    mem_ready = 1'b0;

    // Randomized bundles over a small address window to provoke aliasing
    for (int i = 0; i < 150; i++) begin
      run_bundle(1'($urandom), 32'h1000 + $urandom_range(0, 31), $urandom,
                 1'($urandom), 32'h1000 + $urandom_range(0, 31),
                 $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Saturation: drive enough conflict bundles to pass the counter limit
    for (int i = 0; i < CMAX + 12; i++) begin
      run_bundle(1'b1, 32'h2000 + 32'(4 * (i % 8)), $urandom, 1'b1,
                 32'h2000 + 32'(4 * (i % 8)), 0, 0);
    end
    chk("sat_conflict", 64'(conflict_cnt), 64'(CMAX));
    chk("sat_stall",    64'(stall_cnt),    64'(CMAX));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
